uart_tx: RTL and testbench

Serial UART transmitter that converts a parallel byte into an asynchronous 8N1-style frame (start bit, LSB-first data, stop bit). It is the transmit-side consumer of the 16x oversampling tick from the baud rate generator and shares that tick with the UART receiver. It sits between the host-side interface logic (debug unit / data return path) and the serial `tx` pin.

---
 rtl/uart_tx.sv | 128 ++++++++++++
 tb/tb_uart_tx.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// Serial UART transmitter: start bit, LSB-first data bits, stop bit(s),
// paced by a 16x oversampling tick shared with the receiver.
`timescale 1ns/1ps

module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int SB_TICKS  = 16
) (
    input  logic                 clock,
    input  logic                 reset_i,
    input  logic                 tick,
    input  logic                 tx_start_i,
    input  logic [DATA_BITS-1:0] data_i,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 tx_done_o
);

    localparam int CNT_W = (SB_TICKS > 16) ? $clog2(SB_TICKS) : 4;
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] BIT_TICK_LAST  = CNT_W'(15);
    localparam logic [CNT_W-1:0] STOP_TICK_LAST = CNT_W'(SB_TICKS - 1);
    localparam logic [BIT_W-1:0] BIT_CNT_LAST   = BIT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);
    localparam logic [BIT_W-1:0] BIT_ONE        = BIT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     s_cnt, s_cnt_nxt;
    logic [BIT_W-1:0]     n_cnt, n_cnt_nxt;
    logic [DATA_BITS-1:0] shift_q, shift_nxt;
    logic                 tx_nxt;
    logic                 busy_nxt;
    logic                 done_nxt;

    always_ff @(posedge clock or posedge reset_i) begin
        if (reset_i) begin
            state     <= IDLE;
            s_cnt     <= '0;
            n_cnt     <= '0;
            shift_q   <= '0;
            tx_o      <= 1'b1;
            busy_o    <= 1'b0;
            tx_done_o <= 1'b0;
        end else begin
            state     <= state_nxt;
            s_cnt     <= s_cnt_nxt;
            n_cnt     <= n_cnt_nxt;
            shift_q   <= shift_nxt;
            tx_o      <= tx_nxt;
            busy_o    <= busy_nxt;
            tx_done_o <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        s_cnt_nxt = s_cnt;
        n_cnt_nxt = n_cnt;
        shift_nxt = shift_q;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (tx_start_i) begin
                    state_nxt = START;
                    s_cnt_nxt = '0;
                    shift_nxt = data_i;
                end
            end
            START: begin
                if (tick) begin
                    if (s_cnt == BIT_TICK_LAST) begin
                        state_nxt = DATA;
                        s_cnt_nxt = '0;
                        n_cnt_nxt = '0;
                    end else begin
                        s_cnt_nxt = s_cnt + CNT_ONE;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_cnt == BIT_TICK_LAST) begin
                        s_cnt_nxt = '0;
                        shift_nxt = shift_q >> 1;
                        if (n_cnt == BIT_CNT_LAST) begin
                            state_nxt = STOP;
                        end else begin
                            n_cnt_nxt = n_cnt + BIT_ONE;
                        end
                    end else begin
                        s_cnt_nxt = s_cnt + CNT_ONE;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_cnt == STOP_TICK_LAST) begin
                        state_nxt = IDLE;
                        s_cnt_nxt = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        s_cnt_nxt = s_cnt + CNT_ONE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Line level is decoded from the state being entered so tx_o is a
        // plain flop and the start bit appears one cycle after acceptance.
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_nxt[0];
            default: tx_nxt = 1'b1;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_uart_tx.sv
// Randomized bench for uart_tx: a tick-counting frame model checked every
// cycle, plus directed frames decoded by a mid-bit sampling receiver.
`timescale 1ns/1ps

module tb_uart_tx;

    logic       clock = 1'b0;
    logic       reset_i;
    logic       tick;
    logic       tx_start;
    logic [7:0] data_i;
    logic       tx0, busy0, done0;
    logic       tx1, busy1, done1;

    int total = 0;
    int bad   = 0;
    int tick_mode;

    uart_tx #(.DATA_BITS(8), .SB_TICKS(16)) dut (
        .clock(clock), .reset_i(reset_i), .tick(tick), .tx_start_i(tx_start),
        .data_i(data_i), .tx_o(tx0), .busy_o(busy0), .tx_done_o(done0)
    );

    uart_tx #(.DATA_BITS(8), .SB_TICKS(32)) dut_sb2 (
        .clock(clock), .reset_i(reset_i), .tick(tick), .tx_start_i(tx_start),
        .data_i(data_i), .tx_o(tx1), .busy_o(busy1), .tx_done_o(done1)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Frame model: a frame is a count of ticks since acceptance. Tick n
    // falls in bit slot n/16 (0 = start, 1..8 = data, then stop) and the
    // frame ends once all 16*9+stop ticks have elapsed.
    bit         act_m  [2];
    int         n_m    [2];
    logic [7:0] byte_m [2];
    bit         done_m [2];

    function automatic int frame_ticks(input int i);
        return (i == 0) ? 16 * 9 + 16 : 16 * 9 + 32;
    endfunction

    function automatic logic exp_tx(input int i);
        int p;
        if (!act_m[i]) return 1'b1;
        p = n_m[i] / 16;
        if (p == 0) return 1'b0;
        if (p <= 8) return byte_m[i][p-1];
        return 1'b1;
    endfunction

    always @(posedge clock or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < 2; i++) begin
                act_m[i]  <= 1'b0;
                n_m[i]    <= 0;
                done_m[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                done_m[i] <= 1'b0;
                if (act_m[i]) begin
                    if (tick) begin
                        n_m[i] <= n_m[i] + 1;
                        if (n_m[i] + 1 == frame_ticks(i)) begin
                            act_m[i]  <= 1'b0;
                            done_m[i] <= 1'b1;
                        end
                    end
                end else if (tx_start) begin
                    act_m[i]  <= 1'b1;
                    n_m[i]    <= 0;
                    byte_m[i] <= data_i;
                end
            end
        end
    end

    always @(negedge clock) begin
        check("tx0",   tx0,   exp_tx(0));
        check("busy0", busy0, act_m[0]);
        check("done0", done0, done_m[0]);
        check("tx1",   tx1,   exp_tx(1));
        check("busy1", busy1, act_m[1]);
        check("done1", done1, done_m[1]);
    end

    initial begin
        tick = 1'b0;
        forever begin
            int div;
            @(negedge clock);
            case (tick_mode)
                0: begin div = (div + 1) % 4; tick = (div == 0); end
                1: tick = ($urandom % 3 == 0);
                default: tick = 1'b0;
            endcase
        end
    end

    logic trace [0:4095];
    int   trace_n;
    int   chg [0:63];
    int   nchg;

    task automatic send(input logic [7:0] b);
        tx_start = 1'b1;
        data_i   = b;
        @(negedge clock);
        tx_start = 1'b0;
    endtask

    task automatic capture(input int sel, input int inj_at, output int ndone, output int nbusy);
        logic t, b, d;
        bit   fin;
        trace_n = 0; ndone = 0; nbusy = 0; fin = 1'b0; b = 1'b1;
        for (int k = 0; k < 4000 && !fin; k++) begin
            t = (sel != 0) ? tx1 : tx0;
            b = (sel != 0) ? busy1 : busy0;
            d = (sel != 0) ? done1 : done0;
            trace[k] = t;
            trace_n  = k + 1;
            if (d) ndone++;
            if (b) nbusy++;
            if (k == inj_at) begin
                tx_start = 1'b1;
                data_i   = 8'hFF;
            end else if (k == inj_at + 1) begin
                tx_start = 1'b0;
            end
            if (!b) fin = 1'b1;
            else @(negedge clock);
        end
        if (!fin) check("frame_end", b, 1'b0);
    endtask

    function automatic logic [7:0] decode();
        logic [7:0] r;
        for (int b = 0; b < 8; b++) begin
            int idx = 96 + 64 * b;
            r[b] = (idx < trace_n) ? trace[idx] : 1'bx;
        end
        return r;
    endfunction

    task automatic find_edges();
        nchg = 0;
        for (int k = 1; k < trace_n; k++)
            if (trace[k] !== trace[k-1] && nchg < 64) begin
                chg[nchg] = k;
                nchg++;
            end
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy0 || busy1) && k < 3000) begin
            @(negedge clock);
            k++;
        end
        if (busy0 || busy1) check("idle_wait", busy0 | busy1, 1'b0);
    endtask

    initial begin
        int nd, nb, extra, bad_runs;
        logic [7:0] rx;

        reset_i = 1'b1; tx_start = 1'b0; data_i = 8'h00; tick_mode = 0;
        repeat (3) @(negedge clock);
        check("reset_tx",   tx0,   1'b1);
        check("reset_busy", busy0, 1'b0);
        check("reset_done", done0, 1'b0);
        reset_i = 1'b0;
        repeat (5) @(negedge clock);

        // 0x55 with a 4-clock tick
        send(8'h55);
        capture(0, -1, nd, nb);
        check("x55_rx", decode(), 8'h55);
        check("x55_stop_mid", trace[608], 1'b1);
        check("x55_done", nd, 1);
        check("x55_busy_range", (nb >= 636 && nb <= 644), 1'b1);
        find_edges();
        bad_runs = 0;
        for (int j = 0; j < 8; j++)
            if (chg[j+1] - chg[j] != 64) bad_runs++;
        check("x55_edge_count", nchg, 9);
        check("x55_bit_len", bad_runs, 0);

        // back-to-back 0xA5 then 0x3C launched in the done cycle
        wait_idle();
        send(8'hA5);
        capture(0, -1, nd, nb);
        check("xa5_rx", decode(), 8'hA5);
        check("xa5_done", nd, 1);
        check("gap_high", trace[trace_n-1], 1'b1);
        send(8'h3C);
        capture(0, -1, nd, nb);
        check("gap_one_clock", trace[0], 1'b0);
        check("x3c_rx", decode(), 8'h3C);

        // start request during DATA is ignored
        wait_idle();
        send(8'h00);
        capture(0, 200, nd, nb);
        check("ignore_rx", decode(), 8'h00);
        check("ignore_done", nd, 1);
        extra = 0;
        repeat (100) begin
            @(negedge clock);
            if (busy0 !== 1'b0) extra++;
        end
        check("ignore_no_second", extra, 0);

        // asynchronous reset mid-DATA, then 0x81
        wait_idle();
        send(8'h3C);
        repeat (200) @(negedge clock);
        @(posedge clock);
        #2 reset_i = 1'b1;
        #1;
        check("abort_tx",   tx0,   1'b1);
        check("abort_busy", busy0, 1'b0);
        check("abort_done", done0, 1'b0);
        check("abort_busy_sb2", busy1, 1'b0);
        @(negedge clock);
        reset_i = 1'b0;
        repeat (3) @(negedge clock);
        send(8'h81);
        capture(0, -1, nd, nb);
        check("x81_rx", decode(), 8'h81);
        check("x81_done", nd, 1);

        // tick stall during START
        wait_idle();
        send(8'hC3);
        repeat (8) @(negedge clock);
        tick_mode = 2;
        extra = 0;
        repeat (1000) begin
            @(negedge clock);
            if (tx0 !== 1'b0 || busy0 !== 1'b1) extra++;
        end
        check("freeze_hold", extra, 0);
        tick_mode = 0;
        nd = 0;
        for (int k = 0; k < 3000 && busy0; k++) begin
            @(negedge clock);
            if (done0) nd++;
        end
        check("freeze_done", nd, 1);

        // two stop bits on the SB_TICKS=32 instance
        wait_idle();
        send(8'h0F);
        capture(1, -1, nd, nb);
        check("sb2_rx", decode(), 8'h0F);
        check("sb2_done", nd, 1);
        find_edges();
        check("sb2_stop_len", (nchg > 0) ? (trace_n - 1 - chg[nchg-1]) : 0, 128);

        // randomized ticks, requests and data, with one mid-run reset
        wait_idle();
        tick_mode = 1;
        for (int c = 0; c < 12000; c++) begin
            @(negedge clock);
            tx_start = ($urandom % 50 == 0);
            data_i   = 8'($urandom);
            reset_i  = (c == 6000);
        end
        tx_start = 1'b0;
        reset_i  = 1'b0;
        wait_idle();
        repeat (4) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
